// File: rtl/irq_pkg.sv
// Shared sizes and FSM encoding for the 8-source interrupt controller.
package irq_pkg;
  localparam int NUM_IRQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;
endpackage

// File: rtl/irq_prio_sel.sv
// Combinational 8:3 priority select; bit NUM_IRQ-1 has the highest priority.
module irq_prio_sel
  import irq_pkg::*;
(
  input  logic [NUM_IRQ-1:0] eligible,
  output logic [ID_W-1:0]    sel_id,
  output logic               sel_valid
);

  always_comb begin
    sel_id    = '0;
    sel_valid = |eligible;
    // Ascending scan: the last set bit seen is the highest-priority one.
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (eligible[i]) sel_id = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched pending bits, software mask and a
// req/ack/eoi handshake toward the CPU.
//
// Handshake: irq_req is held with irq_id frozen until irq_ack is seen in a
// cycle where irq_req=1; the transfer completes on that clk edge. eoi is only
// honoured while in_service=1; ack and eoi seen elsewhere are ignored.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter logic [NUM_IRQ-1:0] MASK_RST = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask
);

  irq_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               irq_req_q, irq_req_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic               in_service_q, in_service_d;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] eligible;
  logic [ID_W-1:0]    sel_id;
  logic               sel_valid;

  assign eligible = pending_q & ~mask_q;

  irq_prio_sel u_prio_sel (
    .eligible  (eligible),
    .sel_id    (sel_id),
    .sel_valid (sel_valid)
  );

  always_comb begin
    rise         = irq_in & ~irq_prev_q;
    clr          = '0;
    state_d      = state_q;
    irq_req_d    = irq_req_q;
    irq_id_d     = irq_id_q;
    in_service_d = in_service_q;

    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          irq_id_d  = sel_id;
          irq_req_d = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          irq_req_d     = 1'b0;
          clr[irq_id_q] = 1'b1;
          in_service_d  = 1'b1;
          state_d       = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          in_service_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        irq_req_d    = 1'b0;
        in_service_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase

    // OR-ing the new edges in last lets a fresh edge win over the ack clear.
    pending_d = (pending_q & ~clr) | rise;
    mask_d    = mask_we ? mask_wdata : mask_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      irq_prev_q   <= '0;
      pending_q    <= '0;
      mask_q       <= MASK_RST;
      irq_req_q    <= 1'b0;
      irq_id_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_prev_q   <= irq_in;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      irq_req_q    <= irq_req_d;
      irq_id_q     <= irq_id_d;
      in_service_q <= in_service_d;
    end
  end

  assign irq_req    = irq_req_q;
  assign irq_id     = irq_id_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign mask       = mask_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expected request ids are queued as sources
// are raised and popped when the controller raises irq_req.
module tb_irq_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       irq_req;
  logic [2:0] irq_id;
  logic       irq_ack;
  logic       eoi;
  logic       in_service;
  logic [7:0] pending;
  logic [7:0] mask;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];

  irq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .in_service (in_service),
    .pending    (pending),
    .mask       (mask)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for irq_req, then pop the expected id and compare.
  task automatic wait_req(input string tag, input int max_cycles);
    logic [2:0] exp_id;
    for (int i = 0; i < max_cycles && irq_req !== 1'b1; i++) tick();
    chk({tag, "_req"}, {7'd0, irq_req}, 8'h01);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 8'h01, 8'h00);
    end else begin
      exp_id = exp_q.pop_front();
      chk({tag, "_id"}, {5'd0, irq_id}, {5'd0, exp_id});
    end
  endtask

  task automatic service();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
    irq_ack = 1'b0; eoi = 1'b0;
    tick();
    tick();
    chk("rst_req", {7'd0, irq_req}, 8'h00);
    chk("rst_id", {5'd0, irq_id}, 8'h00);
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_req", {7'd0, irq_req}, 8'h00);
      chk("idle_pend", pending, 8'h00);
      chk("idle_mask", mask, 8'h00);
      chk("idle_insvc", {7'd0, in_service}, 8'h00);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("stray_ack", {7'd0, in_service}, 8'h00);

    // 2: single source, exact latency
    irq_in = 8'h08;
    exp_q.push_back(3'd3);
    tick();
    chk("t2_pend", pending, 8'h08);
    chk("t2_req_early", {7'd0, irq_req}, 8'h00);
    tick();
    wait_req("t2", 0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("t2_ack_pend", pending, 8'h00);
    chk("t2_ack_insvc", {7'd0, in_service}, 8'h01);
    chk("t2_ack_req", {7'd0, irq_req}, 8'h00);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk("t2_eoi_insvc", {7'd0, in_service}, 8'h00);
    tick();
    chk("t2_level_once", {7'd0, irq_req}, 8'h00);
    irq_in = 8'h00;
    tick();

    // 3: priority and freeze
    irq_in = 8'h05;
    exp_q.push_back(3'd2);
    tick();
    tick();
    wait_req("t3a", 0);
    irq_in = 8'h85;
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    chk("t3_freeze_id", {5'd0, irq_id}, 8'h02);
    chk("t3_stray_eoi", {7'd0, irq_req}, 8'h01);
    chk("t3_pend", pending, 8'h85);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("t3_ack_pend", pending, 8'h81);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    wait_req("t3b", 0);
    service();
    wait_req("t3c", 3);
    service();
    irq_in = 8'h00;
    tick();
    chk("t3_done_pend", pending, 8'h00);

    // 4: masking
    mask_we = 1'b1; mask_wdata = 8'h80;
    tick();
    mask_we = 1'b0;
    chk("t4_mask", mask, 8'h80);
    irq_in = 8'h80;
    tick(); tick(); tick();
    chk("t4_pend", pending, 8'h80);
    chk("t4_masked_req", {7'd0, irq_req}, 8'h00);
    mask_we = 1'b1; mask_wdata = 8'h00;
    exp_q.push_back(3'd7);
    tick();
    mask_we = 1'b0;
    chk("t4_unmask_early", {7'd0, irq_req}, 8'h00);
    tick();
    wait_req("t4", 0);
    service();
    irq_in = 8'h00;
    tick();

    // 5: set beats clear
    irq_in = 8'h10;
    exp_q.push_back(3'd4);
    tick();
    tick();
    wait_req("t5a", 0);
    irq_in = 8'h00;
    tick();
    irq_in = 8'h10;
    irq_ack = 1'b1;
    exp_q.push_back(3'd4);
    tick();
    irq_ack = 1'b0;
    chk("t5_pend_kept", pending, 8'h10);
    chk("t5_insvc", {7'd0, in_service}, 8'h01);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    wait_req("t5b", 0);
    service();
    irq_in = 8'h00;
    tick();

    // 6: async reset mid-SERVICE
    irq_in = 8'h02;
    exp_q.push_back(3'd1);
    tick();
    tick();
    wait_req("t6", 0);
    irq_in = 8'h42;
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("t6_insvc", {7'd0, in_service}, 8'h01);
    chk("t6_pend", pending, 8'h40);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_insvc", {7'd0, in_service}, 8'h00);
    chk("t6_async_req", {7'd0, irq_req}, 8'h00);
    chk("t6_async_pend", pending, 8'h00);
    chk("t6_async_mask", mask, 8'h00);
    tick();
    rst = 1'b0;
    irq_in = 8'h00;
    tick();
    chk("t6_after_req", {7'd0, irq_req}, 8'h00);
    chk("sb_leftover", 8'(exp_q.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
8-source interrupt controller that feeds the team's 8:3 priority-encoding stage and consumes its result.
- Latches rising edges of irq_in into a pending register and applies a software mask.
- Hands the highest-priority unmasked pending source (bit 7 highest) to a CPU-side req/ack/eoi handshake.
- Sits between raw peripheral interrupt lines and the processor interrupt input.

Parameters:
NUM_IRQ, 8, number of sources; fixed at 8 because the encoder is 8:3.
ID_W, 3, width of irq_id.
MASK_RST, 8'h00, reset value of the mask register (1 = source masked).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
irq_in  input  8  level interrupt lines, already synchronous to clk.
mask_we  input  1  write strobe for the mask register.
mask_wdata  input  8  new mask value.
irq_req  output  1  interrupt request to the CPU.
irq_id  output  3  index of the requested source; stable while irq_req=1.
irq_ack  input  1  CPU accepts the request.
eoi  input  1  CPU signals end of service.
in_service  output  1  an acknowledged interrupt is being serviced.
pending  output  8  current pending register.
mask  output  8  current mask register.

Behaviour:
- Reset (async, rst=1): irq_prev=0, pending=0, mask=MASK_RST, state=IDLE, irq_req=0, irq_id=0, in_service=0. Deassertion takes effect at the next clk edge.
- Edge detect: edge = irq_in & ~irq_prev. irq_prev <= irq_in every cycle. At each edge, pending <= (pending & ~clr) | edge.
- Set beats clear: if a new edge and the ack-clear hit the same bit in the same cycle, the bit stays pending.
- Mask: on mask_we, mask <= mask_wdata. The new mask is used from the next cycle. Masking does not clear pending bits.
- eligible = pending & ~mask. The combinational 8:3 priority select over eligible yields sel_id and sel_valid (sel_valid=0 when eligible=0).
- FSM states are IDLE, REQ and SERVICE.
  - IDLE: if sel_valid, then irq_id <= sel_id, irq_req <= 1, go to REQ. Otherwise stay.
  - REQ: irq_req=1 and irq_id frozen, even if the mask changes or a higher-priority source arrives. On irq_ack: irq_req <= 0, clear pending[irq_id], in_service <= 1, go to SERVICE.
  - SERVICE: on eoi, in_service <= 0 and go to IDLE. Nested interrupts are not supported.
- Handshake rules: irq_ack outside REQ and eoi outside SERVICE are ignored. irq_ack and eoi in the same cycle follow the current state only.
- Latency: irq_in first sampled high at edge k sets pending at edge k. irq_req is high after edge k+1, i.e. 2 cycles. After eoi at edge m, the next request can assert at edge m+1.
- Level held high produces exactly one event. A new event needs irq_in low for at least 1 cycle.
- Reset mid-handshake aborts: all state clears and irq_req drops asynchronously.

Decomposition:
- Package irq_pkg: NUM_IRQ, ID_W, state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2).
- One sub-module, irq_prio_sel: combinational 8:3 priority select of eligible -> sel_id, sel_valid (bit 7 highest).
- Edge detect, pending/mask registers and FSM stay in irq_ctrl.

Test Plan:
1. Reset then idle: rst pulse with irq_in=0 -> irq_req=0, pending=8'h00, mask=8'h00, in_service=0 for 10 cycles.
2. Single source: irq_in[3] rises at edge k -> pending=8'h08 after k, irq_req=1 and irq_id=3 after k+1. Ack -> pending=8'h00, in_service=1. eoi -> in_service=0, state IDLE.
3. Priority and freeze: irq_in=8'h05 rises -> irq_id=2. While in REQ, irq_in[7] rises -> irq_id stays 2. After ack and eoi -> next irq_id=7, then 0.
4. Masking: mask_wdata=8'h80 written; irq_in[7] rises -> pending[7]=1 but irq_req stays 0. Write mask=8'h00 -> irq_req=1 with irq_id=7 two cycles after the write.
5. Set beats clear: with irq_id=4 in REQ, irq_in[4] falls the cycle before and rises the same cycle as irq_ack -> pending[4] remains 1. A second request with id 4 follows the eoi.
6. Async reset mid-SERVICE: assert rst between edges -> in_service, irq_req and pending go to 0 immediately, without waiting for a clk edge.
